// File: rtl/mig_app_if.sv
// MIG 7-series user (app_*) interface bundle: command, write-data and read-return channels.
interface mig_app_if #(
  parameter int unsigned APP_ADDR_WIDTH = 28,
  parameter int unsigned APP_CMD_WIDTH  = 3,
  parameter int unsigned APP_DATA_WIDTH = 128,
  parameter int unsigned APP_MASK_WIDTH = 16
);
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic [APP_CMD_WIDTH-1:0]  app_cmd;
  logic                      app_en;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_rdy;
  logic                      app_wdf_rdy;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  // Initiator side (user logic driving the controller)
  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  // Responder side (the controller or its model)
  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_app_responder.sv
// Block-RAM backed stand-in for the MIG 7-series app_* interface: calibration delay,
// in-order command/write-data queues, masked writes, fixed-latency reads, optional backpressure.
module mig_app_responder #(
  parameter int unsigned APP_ADDR_WIDTH  = 28,
  parameter int unsigned APP_CMD_WIDTH   = 3,
  parameter int unsigned APP_DATA_WIDTH  = 128,
  parameter int unsigned APP_MASK_WIDTH  = 16,
  parameter int unsigned MEM_DEPTH_LOG2  = 10,
  parameter int unsigned CALIB_CYCLES    = 64,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter bit          BACKPRESSURE_EN = 1'b0
) (
  input  logic     clk,
  input  logic     i_rst_n,
  mig_app_if.slave app,
  output logic     init_calib_complete,
  output logic     o_protocol_err
);

  localparam int unsigned QPTR_W      = $clog2(QUEUE_DEPTH);
  localparam int unsigned QCNT_W      = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned CAL_W       = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned MEM_WORDS   = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned PIPE_STAGES = RD_LATENCY - 1;
  localparam logic [APP_CMD_WIDTH-1:0] CMD_WRITE = APP_CMD_WIDTH'(0);
  localparam logic [APP_CMD_WIDTH-1:0] CMD_READ  = APP_CMD_WIDTH'(1);

  typedef struct packed {
    logic [APP_CMD_WIDTH-1:0]  cmd;
    logic [MEM_DEPTH_LOG2-1:0] idx;
  } cmd_entry_t;

  typedef struct packed {
    logic [APP_DATA_WIDTH-1:0] data;
    logic [APP_MASK_WIDTH-1:0] mask;
  } wd_entry_t;

  // Storage (no reset: RAM contents survive reset, queue slots are guarded by counts)
  cmd_entry_t                cmd_q [QUEUE_DEPTH];
  wd_entry_t                 wd_q  [QUEUE_DEPTH];
  logic [APP_DATA_WIDTH-1:0] mem   [MEM_WORDS];
  logic [APP_DATA_WIDTH-1:0] rd_pipe [PIPE_STAGES];

  // Control state
  logic [QPTR_W-1:0]      cmd_wp, cmd_rp, wd_wp, wd_rp;
  logic [QCNT_W-1:0]      cmd_cnt, wd_cnt;
  logic [CAL_W-1:0]       cal_cnt;
  logic [15:0]            lfsr;
  logic [PIPE_STAGES-1:0] rd_vld;

  // Next-state / decode signals
  cmd_entry_t        head;
  wd_entry_t         wd_head;
  logic              cmd_push, cmd_pop, wd_push, wd_pop;
  logic              head_vld, wd_vld, head_wr, head_rd;
  logic              wr_exec, rd_exec;
  logic [QCNT_W-1:0] cmd_cnt_n, wd_cnt_n;
  logic              calib_n, bp_c_n, bp_w_n, rdy_n, wdf_rdy_n;
  logic [15:0]       lfsr_n;
  logic              proto_bad;

  // Address bits outside the word index are don't-care (sub-word offset and wrap-around)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{app.app_addr[APP_ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app.app_addr[2:0]};

  // Queue handshakes, execute decision and next-cycle ready computation
  always_comb begin
    cmd_push  = app.app_en & app.app_rdy;
    wd_push   = app.app_wdf_wren & app.app_wdf_rdy;
    head      = cmd_q[cmd_rp];
    wd_head   = wd_q[wd_rp];
    head_vld  = (cmd_cnt != '0);
    wd_vld    = (wd_cnt != '0);
    head_wr   = (head.cmd == CMD_WRITE);
    head_rd   = (head.cmd == CMD_READ);
    // A write waits for its data beat; reads and no-ops retire immediately
    cmd_pop   = head_vld & (~head_wr | wd_vld);
    wd_pop    = head_vld & head_wr & wd_vld;
    wr_exec   = wd_pop;
    rd_exec   = head_vld & head_rd;
    cmd_cnt_n = cmd_cnt + QCNT_W'(cmd_push) - QCNT_W'(cmd_pop);
    wd_cnt_n  = wd_cnt + QCNT_W'(wd_push) - QCNT_W'(wd_pop);
    calib_n   = init_calib_complete | (cal_cnt == CAL_W'(CALIB_CYCLES - 1));
    lfsr_n    = lfsr;
    if (init_calib_complete) begin
      lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    bp_c_n    = BACKPRESSURE_EN & lfsr_n[0] & lfsr_n[3];
    bp_w_n    = BACKPRESSURE_EN & lfsr_n[1] & lfsr_n[5];
    rdy_n     = calib_n & (cmd_cnt_n != QCNT_W'(QUEUE_DEPTH)) & ~bp_c_n;
    wdf_rdy_n = calib_n & (wd_cnt_n != QCNT_W'(QUEUE_DEPTH)) & ~bp_w_n;
    proto_bad = (app.app_wdf_wren != app.app_wdf_end) |
                (~init_calib_complete & (app.app_en | app.app_wdf_wren));
  end

  // Control registers: calibration, LFSR, queue pointers, read-valid pipe, registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cal_cnt               <= '0;
      init_calib_complete   <= 1'b0;
      lfsr                  <= 16'hACE1;
      cmd_wp                <= '0;
      cmd_rp                <= '0;
      cmd_cnt               <= '0;
      wd_wp                 <= '0;
      wd_rp                 <= '0;
      wd_cnt                <= '0;
      rd_vld                <= '0;
      app.app_rdy           <= 1'b0;
      app.app_wdf_rdy       <= 1'b0;
      app.app_rd_data_valid <= 1'b0;
      app.app_rd_data_end   <= 1'b0;
      app.app_rd_data       <= '0;
      o_protocol_err        <= 1'b0;
    end else begin
      if (!init_calib_complete) cal_cnt <= cal_cnt + CAL_W'(1);
      init_calib_complete <= calib_n;
      lfsr                <= lfsr_n;
      if (cmd_push) cmd_wp <= cmd_wp + QPTR_W'(1);
      if (cmd_pop)  cmd_rp <= cmd_rp + QPTR_W'(1);
      if (wd_push)  wd_wp  <= wd_wp + QPTR_W'(1);
      if (wd_pop)   wd_rp  <= wd_rp + QPTR_W'(1);
      cmd_cnt         <= cmd_cnt_n;
      wd_cnt          <= wd_cnt_n;
      app.app_rdy     <= rdy_n;
      app.app_wdf_rdy <= wdf_rdy_n;
      rd_vld[0]       <= rd_exec;
      for (int i = 1; i < PIPE_STAGES; i++) rd_vld[i] <= rd_vld[i-1];
      app.app_rd_data_valid <= rd_vld[PIPE_STAGES-1];
      app.app_rd_data_end   <= rd_vld[PIPE_STAGES-1];
      if (rd_vld[PIPE_STAGES-1]) app.app_rd_data <= rd_pipe[PIPE_STAGES-1];
      if (proto_bad) o_protocol_err <= 1'b1;
    end
  end

  // Queue slots, byte-masked RAM write and RAM read data pipeline
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_q[cmd_wp] <= {app.app_cmd, app.app_addr[MEM_DEPTH_LOG2+2:3]};
    if (wd_push)  wd_q[wd_wp]   <= {app.app_wdf_data, app.app_wdf_mask};
    if (wr_exec) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!wd_head.mask[b]) mem[head.idx][8*b +: 8] <= wd_head.data[8*b +: 8];
      end
    end
    rd_pipe[0] <= mem[head.idx];
    for (int i = 1; i < PIPE_STAGES; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: vector table plus hand sequences for queue-full,
// back-to-back reads, reset during reads and protocol-error detection.
module tb_mig_app_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib, perr;
  int   cyc;
  int   nvec = 0;
  int   nmis = 0;

  mig_app_if bus ();

  mig_app_responder dut (
    .clk                 (clk),
    .i_rst_n             (rst_n),
    .app                 (bus),
    .init_calib_complete (calib),
    .o_protocol_err      (perr)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; sampled on negedges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int           kind;   // 0 write (data beat then command), 1 read, 2 no-op command
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
    logic [127:0] exp;
  } vec_t;

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic [2:0] c, input logic [27:0] a, output int t, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.app_cmd  = c;
    bus.app_addr = a;
    bus.app_en   = 1'b1;
    while (bus.app_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.app_rdy === 1'b1);
    t  = cyc;
    @(negedge clk);
    bus.app_en = 1'b0;
  endtask

  task automatic send_data(input logic [127:0] d, input logic [15:0] m, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.app_wdf_data = d;
    bus.app_wdf_mask = m;
    bus.app_wdf_wren = 1'b1;
    bus.app_wdf_end  = 1'b1;
    while (bus.app_wdf_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.app_wdf_rdy === 1'b1);
    @(negedge clk);
    bus.app_wdf_wren = 1'b0;
    bus.app_wdf_end  = 1'b0;
  endtask

  task automatic do_write(input string name, input logic [27:0] a, input logic [127:0] d,
                          input logic [15:0] m);
    int t;
    bit ok;
    send_data(d, m, ok);
    check_b({name, " data accepted"}, ok, 1'b1);
    issue_cmd(3'b000, a, t, ok);
    check_b({name, " cmd accepted"}, ok, 1'b1);
  endtask

  task automatic do_read(input string name, input logic [27:0] a, input logic [127:0] exp);
    int t, n;
    bit ok;
    issue_cmd(3'b001, a, t, ok);
    n = 0;
    while (bus.app_rd_data_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_i({name, " latency"}, cyc - t, 5);
    check_w({name, " data"}, bus.app_rd_data, exp);
    check_b({name, " end"}, bus.app_rd_data_end, 1'b1);
    @(negedge clk);
    check_b({name, " one-cycle valid"}, bus.app_rd_data_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check_b({name, " calib"},   calib, 1'b0);
    check_b({name, " rdy"},     bus.app_rdy, 1'b0);
    check_b({name, " wdf_rdy"}, bus.app_wdf_rdy, 1'b0);
    check_b({name, " valid"},   bus.app_rd_data_valid, 1'b0);
    check_b({name, " end"},     bus.app_rd_data_end, 1'b0);
    check_b({name, " err"},     perr, 1'b0);
    check_w({name, " rd_data"}, bus.app_rd_data, 128'h0);
  endtask

  localparam logic [127:0] D0   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] W1   = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] D0M  = 128'h0123_4567_89AB_CDEF_0123_4567_1111_1111;
  localparam logic [127:0] D2   = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
  localparam logic [127:0] P0   = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
  localparam logic [127:0] P3   = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;

  vec_t         tbl [11];
  logic [127:0] exp_b2b [4];
  int           vc [8];
  logic [127:0] vd [8];
  int           nv, nspur, t0 [4], tq;
  bit           early_ok, rdy_ok, ok5, okd;

  initial begin
    tbl[0]  = '{0, 28'h040,     D0,             16'h0000, 128'h0};
    tbl[1]  = '{1, 28'h040,     128'h0,         16'h0000, D0};
    tbl[2]  = '{0, 28'h008,     {128{1'b1}},    16'h0000, 128'h0};
    tbl[3]  = '{0, 28'h008,     128'h0,         16'h00FF, 128'h0};
    tbl[4]  = '{1, 28'h008,     128'h0,         16'h0000, W1};
    tbl[5]  = '{0, 28'h047,     {4{32'h1111_1111}}, 16'hFFF0, 128'h0};
    tbl[6]  = '{2, 28'h040,     128'h0,         16'h0000, 128'h0};
    tbl[7]  = '{1, 28'h040,     128'h0,         16'h0000, D0M};
    tbl[8]  = '{0, 28'h8000010, D2,             16'h0000, 128'h0};
    tbl[9]  = '{1, 28'h010,     128'h0,         16'h0000, D2};
    tbl[10] = '{1, 28'h2008,    128'h0,         16'h0000, W1};

    bus.app_addr = '0; bus.app_cmd = '0; bus.app_en = 1'b0;
    bus.app_wdf_data = '0; bus.app_wdf_mask = '0;
    bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;

    // Reset state, then calibration edge at cycle 64
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    early_ok = 1'b1;
    while (cyc < 63) begin
      @(negedge clk);
      if (calib !== 1'b0 || bus.app_rdy !== 1'b0 || bus.app_wdf_rdy !== 1'b0) early_ok = 1'b0;
    end
    check_b("calib low through cycle 63", early_ok, 1'b1);
    @(negedge clk);
    check_i("calib cycle", cyc, 64);
    check_b("calib at 64", calib, 1'b1);
    check_b("rdy at 64", bus.app_rdy, 1'b1);
    check_b("wdf_rdy at 64", bus.app_wdf_rdy, 1'b1);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      case (tbl[i].kind)
        0: do_write($sformatf("vec%0d write", i), tbl[i].addr, tbl[i].data, tbl[i].mask);
        1: do_read($sformatf("vec%0d read", i), tbl[i].addr, tbl[i].exp);
        default: begin
          issue_cmd(3'b011, tbl[i].addr, tq, okd);
          check_b($sformatf("vec%0d noop accepted", i), okd, 1'b1);
          nspur = 0;
          repeat (8) begin
            @(negedge clk);
            if (bus.app_rd_data_valid === 1'b1) nspur++;
          end
          check_i($sformatf("vec%0d noop no valid", i), nspur, 0);
        end
      endcase
    end

    // Four write commands without data fill the command queue
    for (int k = 0; k < 4; k++) begin
      issue_cmd(3'b000, 28'h100 + 28'(k * 8), tq, okd);
      check_b($sformatf("fill cmd%0d accepted", k), okd, 1'b1);
    end
    check_b("rdy low when full", bus.app_rdy, 1'b0);
    repeat (4) @(negedge clk);
    check_b("rdy stays low while stalled", bus.app_rdy, 1'b0);
    fork
      issue_cmd(3'b000, 28'h120, tq, ok5);
      begin
        for (int k = 0; k < 4; k++) begin
          send_data({4{32'hC0DE_0000 | 32'(k)}}, 16'h0000, okd);
          check_b($sformatf("fill data%0d accepted", k), okd, 1'b1);
        end
      end
    join
    check_b("fifth cmd accepted after drain", ok5, 1'b1);
    send_data({4{32'hC0DE_0004}}, 16'h0000, okd);
    check_b("fifth data accepted", okd, 1'b1);
    for (int k = 0; k < 5; k++)
      do_read($sformatf("fill rd%0d", k), 28'h100 + 28'(k * 8), {4{32'hC0DE_0000 | 32'(k)}});

    // Command-before-data for word 0, data-before-command for word 3
    issue_cmd(3'b000, 28'h000, tq, okd);
    repeat (2) @(negedge clk);
    send_data(P0, 16'h0000, okd);
    send_data(P3, 16'h0000, okd);
    repeat (3) @(negedge clk);
    issue_cmd(3'b000, 28'h018, tq, okd);
    check_b("early data cmd accepted", okd, 1'b1);

    // Four back-to-back reads
    exp_b2b[0] = P0; exp_b2b[1] = W1; exp_b2b[2] = D2; exp_b2b[3] = P3;
    rdy_ok = 1'b1;
    nv = 0;
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          bus.app_en = 1'b1; bus.app_cmd = 3'b001; bus.app_addr = 28'(i * 8);
          t0[i] = cyc;
          if (bus.app_rdy !== 1'b1) rdy_ok = 1'b0;
          @(negedge clk);
        end
        bus.app_en = 1'b0;
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (bus.app_rd_data_valid === 1'b1 && nv < 8) begin
            vc[nv] = cyc; vd[nv] = bus.app_rd_data; nv++;
          end
        end
      end
    join
    check_b("b2b rdy held", rdy_ok, 1'b1);
    check_i("b2b valid count", nv, 4);
    for (int i = 0; i < 4; i++) begin
      check_i($sformatf("b2b%0d cycle", i), vc[i], t0[i] + 5);
      check_w($sformatf("b2b%0d data", i), vd[i], exp_b2b[i]);
    end
    check_b("no err in clean traffic", perr, 1'b0);

    // Reset with two reads in flight
    @(negedge clk);
    bus.app_en = 1'b1; bus.app_cmd = 3'b001; bus.app_addr = 28'h000;
    @(negedge clk);
    bus.app_addr = 28'h008;
    @(negedge clk);
    bus.app_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nspur = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.app_rd_data_valid !== 1'b0) nspur++;
    end
    check_i("no valid after reset", nspur, 0);
    check_b("calib restarted", calib, 1'b0);
    nspur = 0;
    while (calib !== 1'b1 && nspur < 100) begin
      @(negedge clk);
      nspur++;
    end
    check_i("recalib cycle", cyc, 64);

    // wren without end sets the sticky error
    check_b("err clear before violation", perr, 1'b0);
    bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b0;
    @(negedge clk);
    bus.app_wdf_wren = 1'b0;
    check_b("err after wren!=end", perr, 1'b1);
    repeat (5) @(negedge clk);
    check_b("err sticky", perr, 1'b1);

    // app_en during calibration also flags an error
    rst_n = 1'b0;
    #1;
    check_b("err cleared by reset", perr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.app_en = 1'b1; bus.app_cmd = 3'b001;
    @(negedge clk);
    bus.app_en = 1'b0;
    check_b("err on early app_en", perr, 1'b1);
    check_b("early cmd not accepted", bus.app_rdy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
